pc_fetch_unit: RTL and testbench

//  Instruction-fetch front end of the MIPS core: owns the PC, drives the im_4k word address,

---
 rtl/mips_fetch_pkg.sv | 12 +
 rtl/pc_fetch_unit_if.sv | 27 ++
 rtl/pc_fetch_unit_pc_next_sel.sv | 30 +++
 rtl/pc_fetch_unit.sv | 78 +++++++
 tb/tb_pc_fetch_unit.sv | 137 +++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared constants and helpers for the instruction-fetch front end
package mips_fetch_pkg;

    localparam int          PC_W         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch-side bus: im_4k port, redirect input, decode handshake
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    import mips_fetch_pkg::*;

    logic [ADDR_W-1:0] imem_addr;
    logic [PC_W-1:0]   imem_rdata;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [PC_W-1:0]   instr_pc;
    logic [PC_W-1:0]   instr;
    logic              misalign_err;

    modport master (
        output imem_addr, instr_valid, instr_pc, instr, misalign_err,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_addr, instr_valid, instr_pc, instr, misalign_err,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// rtl/pc_fetch_unit_pc_next_sel.sv - next-PC and im_4k address selection, redirect first
module pc_next_sel
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [PC_W-1:0]   pc_q,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              hold,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   pc_d,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              misalign
);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
        end else if (!hold) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // While stalled, re-read the pending word so imem_rdata still holds it on release.
    assign imem_addr = hold ? pend_addr : pc_q[ADDR_W+1:2];
    assign misalign  = redirect_valid & (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC owner, im_4k read pipeline and decode output register
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 10
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_unit_if.master bus
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            pend_q;
    logic [PC_W-1:0] pend_pc_q;
    logic            out_valid_q;
    logic [PC_W-1:0] out_pc_q;
    logic [PC_W-1:0] out_instr_q;
    logic            misalign_q;
    logic            misalign;
    logic            accept;
    logic            hold;

    assign accept = pend_q & (~out_valid_q | bus.instr_ready);
    assign hold   = pend_q & ~accept;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .pc_q           (pc_q),
        .pend_addr      (pend_pc_q[ADDR_W+1:2]),
        .hold           (hold),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .pc_d           (pc_d),
        .imem_addr      (bus.imem_addr),
        .misalign       (misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= NOP;
            misalign_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign;
            // A redirect discards both the in-flight read and the presented word.
            if (bus.redirect_valid) begin
                pend_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (!hold) begin
                    pend_q    <= 1'b1;
                    pend_pc_q <= pc_q;
                end
                if (accept) begin
                    out_valid_q <= 1'b1;
                    out_pc_q    <= pend_pc_q;
                    out_instr_q <= bus.imem_rdata;
                end else if (out_valid_q && bus.instr_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.instr_valid  = out_valid_q;
    assign bus.instr_pc     = out_pc_q;
    assign bus.instr        = out_instr_q;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed-vector bench for pc_fetch_unit with an im_4k model
module tb_pc_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    logic [31:0] mem [0:1023];

    pc_fetch_unit_if #(.ADDR_W(10)) bus ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .ADDR_W   (10)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, ".valid"}, {31'd0, bus.instr_valid}, 32'd1);
        chk({tag, ".pc"},    bus.instr_pc, pc);
        chk({tag, ".instr"}, bus.instr, ins);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
        rst_n              = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        #3;
        chk("rst.valid",    {31'd0, bus.instr_valid}, 32'd0);
        chk("rst.pc",       bus.instr_pc, 32'h0);
        chk("rst.instr",    bus.instr, 32'h0);
        chk("rst.misalign", {31'd0, bus.misalign_err}, 32'd0);
        chk("rst.addr",     {22'd0, bus.imem_addr}, 32'h000);
        step();
        step();
        rst_n = 1'b1;

        // 1: first word two edges after release, then one per cycle
        step();
        chk("t1.e1.valid", {31'd0, bus.instr_valid}, 32'd0);
        step(); expect_out("t1.a", 32'h3000, 32'h1000_0000);
        step(); expect_out("t1.b", 32'h3004, 32'h1000_0001);
        step(); expect_out("t1.c", 32'h3008, 32'h1000_0002);

        // 2: decode stall
        bus.instr_ready = 1'b0;
        #1;
        chk("t2.addr0", {22'd0, bus.imem_addr}, 32'h003);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("t2.hold", 32'h3008, 32'h1000_0002);
            chk("t2.addr", {22'd0, bus.imem_addr}, 32'h003);
        end
        bus.instr_ready = 1'b1;
        step(); expect_out("t2.d", 32'h300C, 32'h1000_0003);
        step(); expect_out("t2.e", 32'h3010, 32'h1000_0004);

        // 3: redirect while 0x3010 presented
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3040;
        step();
        bus.redirect_valid = 1'b0;
        chk("t3.flush", {31'd0, bus.instr_valid}, 32'd0);
        chk("t3.nomis", {31'd0, bus.misalign_err}, 32'd0);
        step();
        chk("t3.gap", {31'd0, bus.instr_valid}, 32'd0);
        step(); expect_out("t3.a", 32'h3040, 32'h1000_0010);
        step(); expect_out("t3.b", 32'h3044, 32'h1000_0011);

        // 4: misaligned redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3042;
        step();
        bus.redirect_valid = 1'b0;
        chk("t4.mis1",  {31'd0, bus.misalign_err}, 32'd1);
        chk("t4.flush", {31'd0, bus.instr_valid}, 32'd0);
        step();
        chk("t4.mis0", {31'd0, bus.misalign_err}, 32'd0);
        step(); expect_out("t4.a", 32'h3040, 32'h1000_0010);

        // 5: wrap at top of address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("t5.addr_top", {22'd0, bus.imem_addr}, 32'h3FF);
        step();
        chk("t5.addr_wrap", {22'd0, bus.imem_addr}, 32'h000);
        step(); expect_out("t5.a", 32'hFFFF_FFFC, 32'h1000_03FF);
        step(); expect_out("t5.b", 32'h0000_0000, 32'h1000_0000);

        // 6: asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("t6.pc",    bus.instr_pc, 32'h0);
        chk("t6.instr", bus.instr, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6.e1.valid", {31'd0, bus.instr_valid}, 32'd0);
        step(); expect_out("t6.a", 32'h3000, 32'h1000_0000);
        step(); expect_out("t6.b", 32'h3004, 32'h1000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
